// File: rtl/inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch : PC owner, single-outstanding imem fetch, 2-entry {pc,ins} queue
// Rev 1.0
// ----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        jmp_flag,
  input  logic [31:0] jmp_addr,
  output logic [31:0] ins,
  output logic [31:0] pc_o,
  output logic        ins_valid,
  input  logic        dec_ready
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic [31:0] head_pc, head_pc_nxt, head_ins, head_ins_nxt;
  logic [31:0] tail_pc, tail_pc_nxt, tail_ins, tail_ins_nxt;
  logic [1:0]  count, count_nxt;
  logic        accept, push, pop;
  logic        unused_jmp_lsb;

  assign unused_jmp_lsb = ^jmp_addr[1:0];

  // A redirect suppresses the request so the new target is issued cleanly next cycle.
  assign imem_req  = rst_n && (state == ST_REQ) && (count < 2'd2) && !jmp_flag;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;

  assign ins_valid = (count != 2'd0);
  assign push      = (state == ST_WAIT) && imem_rvalid && !jmp_flag;
  assign pop       = ins_valid && dec_ready && !jmp_flag;

  assign ins  = ins_valid ? head_ins : 32'h0;
  assign pc_o = ins_valid ? head_pc  : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ: begin
        if (accept) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)   state_nxt = ST_REQ;
        else if (jmp_flag) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    if (jmp_flag) begin
      pc_nxt = {jmp_addr[31:2], 2'b00};
    end else if (accept) begin
      pc_nxt     = pc + 32'd4;
      req_pc_nxt = pc;
    end
  end

  // Queue update; push only ever lands with count<2 since a single request is in flight.
  always_comb begin
    head_pc_nxt  = head_pc;
    head_ins_nxt = head_ins;
    tail_pc_nxt  = tail_pc;
    tail_ins_nxt = tail_ins;
    count_nxt    = count;
    if (jmp_flag) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc_nxt  = req_pc;
            head_ins_nxt = imem_rdata;
          end else begin
            tail_pc_nxt  = req_pc;
            tail_ins_nxt = imem_rdata;
          end
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          head_pc_nxt  = tail_pc;
          head_ins_nxt = tail_ins;
          count_nxt    = count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc_nxt  = req_pc;
            head_ins_nxt = imem_rdata;
          end else begin
            head_pc_nxt  = tail_pc;
            head_ins_nxt = tail_ins;
            tail_pc_nxt  = req_pc;
            tail_ins_nxt = imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      head_pc  <= 32'h0;
      head_ins <= 32'h0;
      tail_pc  <= 32'h0;
      tail_ins <= 32'h0;
      count    <= 2'd0;
    end else begin
      pc       <= pc_nxt;
      req_pc   <= req_pc_nxt;
      head_pc  <= head_pc_nxt;
      head_ins <= head_ins_nxt;
      tail_pc  <= tail_pc_nxt;
      tail_ins <= tail_ins_nxt;
      count    <= count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inst_fetch : randomized memory/decode environment with scoreboard checking
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        jmp_flag = 1'b0;
  logic [31:0] jmp_addr = 32'h0;
  logic [31:0] ins;
  logic [31:0] pc_o;
  logic        ins_valid;
  logic        dec_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .jmp_flag   (jmp_flag),
    .jmp_addr   (jmp_addr),
    .ins        (ins),
    .pc_o       (pc_o),
    .ins_valid  (ins_valid),
    .dec_ready  (dec_ready)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];        // {pc, ins} words delivered to the fetch queue, not yet consumed
  logic [31:0] model_pc;
  bit          outstanding = 0;
  bit          out_drop = 0;
  logic [31:0] out_addr = 32'h0;
  int          acc_cyc = 0;
  int          cyc = 0;
  bit          stale_pending = 0;
  bit          tgt_fixed = 0;
  logic [31:0] tgt_val = 32'h0;
  logic [63:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Decode-side monitor: every consumed instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && ins_valid && dec_ready && !jmp_flag) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_empty: got pc %h ins %h expected no instruction", pc_o, ins);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dec_pc", pc_o, mon_e[63:32]);
        chk("dec_ins", ins, mon_e[31:0]);
      end
    end
  end

  // One cycle: starts and ends at posedge+1.
  task automatic step(input int ack_p, input int rv_p, input int rdy_p, input int jmp_p);
    bit          exp_req;
    bit          rv;
    bit          jmp;
    logic [31:0] tgt;
    chk("ins_valid", {31'b0, ins_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() == 0) begin
      chk("nop_ins", ins, 32'h0);
      chk("nop_pc", pc_o, 32'h0);
    end
    jmp = roll(jmp_p);
    if (tgt_fixed)                         tgt = tgt_val;
    else if ($urandom_range(3, 0) == 0)    tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else                                   tgt = $urandom;
    rv          = stale_pending ? 1'b1 : (outstanding && (cyc > acc_cyc) && roll(rv_p));
    imem_ack    = stale_pending ? 1'b0 : roll(ack_p);
    imem_rvalid = rv;
    imem_rdata  = (rv && outstanding) ? mem_word(out_addr) : $urandom;
    jmp_flag    = jmp;
    jmp_addr    = tgt;
    dec_ready   = roll(rdy_p);
    stale_pending = 0;
    #1;
    exp_req = !outstanding && (exp_q.size() < 2) && !jmp;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, model_pc);
    if (rv) begin
      if (outstanding && !out_drop && !jmp) exp_q.push_back({out_addr, mem_word(out_addr)});
      outstanding = 0;
    end else if (jmp && outstanding) begin
      out_drop = 1;
    end
    if (jmp) begin
      exp_q.delete();
      model_pc = {tgt[31:2], 2'b00};
    end
    if (exp_req && imem_ack) begin
      outstanding = 1;
      out_drop    = 0;
      out_addr    = model_pc;
      model_pc    = model_pc + 32'd4;
      acc_cyc     = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit stale);
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    jmp_flag    = 1'b0;
    dec_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, ins_valid}, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    exp_q.delete();
    model_pc      = RST_PC;
    outstanding   = 0;
    out_drop      = 0;
    stale_pending = stale;
    rst_n         = 1'b1;
  endtask

  // mode 0: live request to addr a; 1: live request plus one queued word; 2: any request in flight
  task automatic seek(input string nm, input int ack_p, input int rv_p, input int rdy_p,
                      input int mode, input logic [31:0] a);
    bit hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      case (mode)
        0:       hit = outstanding && !out_drop && (out_addr == a);
        1:       hit = outstanding && !out_drop && (exp_q.size() == 1) && (cyc > acc_cyc);
        default: hit = outstanding;
      endcase
      if (!hit) step(ack_p, rv_p, rdy_p, 0);
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: got no matching state expected reached within 200 cycles", nm);
    end
  endtask

  task automatic forced_jump(input logic [31:0] t, input int rv_p);
    tgt_fixed = 1;
    tgt_val   = t;
    step(0, rv_p, 0, 100);
    tgt_fixed = 0;
  endtask

  initial begin
    model_pc = RST_PC;
    #1;
    // Streaming at full speed from reset.
    do_reset(0);
    repeat (12) step(100, 100, 100, 0);

    // Decode stalled: queue fills, single pop frees a slot.
    do_reset(0);
    repeat (10) step(100, 100, 0, 0);
    step(100, 100, 100, 0);
    repeat (6) step(100, 100, 0, 0);
    repeat (8) step(100, 100, 100, 0);

    // Redirect while the request to 0x10 is outstanding.
    do_reset(0);
    seek("wait10", 100, 100, 100, 0, 32'h10);
    forced_jump(32'h0000_0103, 0);
    repeat (10) step(100, 100, 100, 0);

    // Redirect coincident with a response while one word is queued.
    do_reset(0);
    seek("cnt1", 100, 50, 0, 1, 32'h0);
    forced_jump(32'h0000_0200, 100);
    repeat (8) step(100, 100, 100, 0);

    // Address wrap past 0xFFFF_FFFC.
    forced_jump(32'hFFFF_FFF8, 0);
    repeat (12) step(100, 100, 100, 0);

    // Reset while waiting, then a stale response right after release.
    seek("inflight", 100, 0, 100, 2, 32'h0);
    do_reset(1);
    repeat (10) step(100, 100, 100, 0);

    // Randomized traffic with varying memory/decode behaviour.
    for (int blk = 0; blk < 20; blk++) begin
      int ap, rp, dp, jp;
      ap = int'($urandom_range(100, 30));
      rp = int'($urandom_range(100, 20));
      dp = int'($urandom_range(100, 0));
      jp = int'($urandom_range(10, 0));
      if ($urandom_range(4, 0) == 0) do_reset($urandom_range(1, 0) == 1);
      repeat (100) step(ap, rp, dp, jp);
    end
    repeat (20) step(100, 100, 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
